// File: rtl/mm_row_engine_if.sv
// Bundle of the start, B-row read and result handshakes for mm_row_engine.
// slave = engine side, master = the surrounding pipeline / memory side.
interface mm_row_engine_if #(
    parameter int LANES  = 8,
    parameter int W      = 32,
    parameter int ADDR_W = 32
);
    logic                  start_valid;
    logic                  start_ready;
    logic [LANES*W-1:0]    a_row;
    logic [ADDR_W-1:0]     b_base;
    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_ack;
    logic [LANES*W-1:0]    rd_data;
    logic                  res_valid;
    logic                  res_ready;
    logic [LANES*W-1:0]    res_row;
    logic                  busy;

    modport slave (
        input  start_valid, a_row, b_base,
        input  rd_ack, rd_data, res_ready,
        output start_ready, rd_req, rd_addr,
        output res_valid, res_row, busy
    );

    modport master (
        output start_valid, a_row, b_base,
        output rd_ack, rd_data, res_ready,
        input  start_ready, rd_req, rd_addr,
        input  res_valid, res_row, busy
    );
endinterface

// File: rtl/mm_row_engine.sv
// Row engine: C_row = sum_k a_k * B_row_k, lane-wise, mod 2^W.
// Ports: clk, reset (sync, active-high), bus (mm_row_engine_if.slave).
module mm_row_engine #(
    parameter int LANES     = 8,
    parameter int W         = 32,
    parameter int ADDR_W    = 32,
    parameter int ROW_BYTES = 32
) (
    input  logic              clk,
    input  logic              reset,
    mm_row_engine_if.slave    bus
);
    localparam int K_W = $clog2(LANES);
    localparam logic [K_W-1:0] K_LAST = K_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ROW_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [K_W-1:0]            k;
    logic [ADDR_W-1:0]         base_q;
    logic [LANES-1:0][W-1:0]   a_q;
    logic [LANES-1:0][W-1:0]   acc;
    logic [LANES-1:0][W-1:0]   acc_next;
    logic [LANES-1:0][W-1:0]   res_q;
    logic [W-1:0]              a_k;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        bus.start_ready = 1'b0;
        bus.rd_req      = 1'b0;
        bus.rd_addr     = '0;
        bus.res_valid   = 1'b0;
        bus.busy        = 1'b1;
        unique case (state)
            IDLE: begin
                bus.start_ready = 1'b1;
                bus.busy        = 1'b0;
                if (bus.start_valid) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = base_q + ADDR_W'(k) * STRIDE;
                if (bus.rd_ack && k == K_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Products are kept at W bits, so each MAC wraps mod 2^W.
    always_comb begin
        a_k = a_q[k];
        for (int j = 0; j < LANES; j++) begin
            acc_next[j] = acc[j] + a_k * bus.rd_data[j*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k      <= '0;
            base_q <= '0;
            a_q    <= '0;
            acc    <= '0;
            res_q  <= '0;
        end else begin
            if (state == IDLE && bus.start_valid) begin
                a_q    <= bus.a_row;
                base_q <= bus.b_base;
                acc    <= '0;
                k      <= '0;
            end
            if (state == REQ && bus.rd_ack) begin
                acc <= acc_next;
                k   <= k + 1'b1;
                if (k == K_LAST) begin
                    res_q <= acc_next;
                end
            end
        end
    end

    assign bus.res_row = res_q;
endmodule
